// File: rtl/cache_controller_pkg.sv
// Shared widths and FSM encoding for the two-way write-through data cache.
package cache_controller_pkg;
  localparam int ADDRESS_LEN     = 32;
  localparam int REGISTER_LEN    = 32;
  localparam int CACHE_SET_COUNT = 64;
  localparam int CACHE_INDEX_LEN = 6;
  localparam int CACHE_TAG_LEN   = 10;

  typedef enum logic [1:0] {
    CACHE_IDLE  = 2'd0,
    CACHE_FILL0 = 2'd1,
    CACHE_FILL1 = 2'd2,
    CACHE_WRITE = 2'd3
  } cache_state_e;
endpackage

// File: rtl/cache_controller_set_array.sv
// Tag/valid/data storage for both ways plus per-set LRU; combinational read, registered writes.
// Only valid and LRU are reset: tag and data are meaningless while valid is clear.
module cache_set_array
  import cache_controller_pkg::*;
#(
  parameter int SET_COUNT = CACHE_SET_COUNT,
  parameter int TAG_LEN   = CACHE_TAG_LEN,
  localparam int IDX_W    = $clog2(SET_COUNT)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [IDX_W-1:0]                     i_index,
  output logic [1:0]                           o_valid,
  output logic [1:0][TAG_LEN-1:0]              o_tag,
  output logic [1:0][1:0][REGISTER_LEN-1:0]    o_data,
  output logic                                 o_lru,
  input  logic                                 i_fill_en,
  input  logic                                 i_fill_way,
  input  logic [TAG_LEN-1:0]                   i_fill_tag,
  input  logic [1:0][REGISTER_LEN-1:0]         i_fill_data,
  input  logic                                 i_upd_en,
  input  logic                                 i_upd_way,
  input  logic                                 i_upd_word,
  input  logic [REGISTER_LEN-1:0]              i_upd_data,
  input  logic                                 i_lru_en,
  input  logic                                 i_lru_val
);
  logic [1:0]                        r_valid [SET_COUNT];
  logic [SET_COUNT-1:0]              r_lru;
  logic [1:0][TAG_LEN-1:0]           r_tag   [SET_COUNT];
  logic [1:0][1:0][REGISTER_LEN-1:0] r_data  [SET_COUNT];

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];
  assign o_lru   = r_lru[i_index];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SET_COUNT; s++) r_valid[s] <= 2'b00;
      r_lru <= '0;
    end else begin
      if (i_fill_en) r_valid[i_index][i_fill_way] <= 1'b1;
      if (i_lru_en)  r_lru[i_index] <= i_lru_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[i_index][i_fill_way]  <= i_fill_tag;
      r_data[i_index][i_fill_way] <= i_fill_data;
    end else if (i_upd_en) begin
      r_data[i_index][i_upd_way][i_upd_word] <= i_upd_data;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate cache: read hits in 0 cycles, misses fill two words,
// writes always go to SRAM; ready=0 freezes the pipeline until the access finishes.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int SET_COUNT = CACHE_SET_COUNT,
  parameter int TAG_LEN   = CACHE_TAG_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read_en,
  input  logic                    mem_write_en,
  input  logic [ADDRESS_LEN-1:0]  mem_address,
  input  logic [REGISTER_LEN-1:0] mem_write_data,
  output logic [REGISTER_LEN-1:0] mem_read_data,
  output logic                    ready,
  output logic                    sram_read_en,
  output logic                    sram_write_en,
  output logic [ADDRESS_LEN-1:0]  sram_address,
  output logic [REGISTER_LEN-1:0] sram_write_data,
  input  logic [REGISTER_LEN-1:0] sram_read_data,
  input  logic                    sram_ready
);
  localparam int IDX_W = $clog2(SET_COUNT);

  cache_state_e                      r_state, w_next;
  logic [REGISTER_LEN-1:0]           r_word0;
  logic [IDX_W-1:0]                  w_index;
  logic [TAG_LEN-1:0]                w_tag;
  logic                              w_word;
  logic [1:0]                        w_valid;
  logic [1:0][TAG_LEN-1:0]           w_way_tag;
  logic [1:0][1:0][REGISTER_LEN-1:0] w_way_data;
  logic                              w_lru;
  logic [1:0]                        w_match;
  logic                              w_hit, w_hit_way, w_victim;
  logic                              w_fill_en, w_upd_en, w_lru_en, w_lru_val, w_word0_ld;

  assign w_index = mem_address[3 +: IDX_W];
  assign w_tag   = mem_address[3 + IDX_W +: TAG_LEN];
  assign w_word  = mem_address[2];

  assign w_match[0] = w_valid[0] && (w_way_tag[0] == w_tag);
  assign w_match[1] = w_valid[1] && (w_way_tag[1] == w_tag);
  assign w_hit      = |w_match;
  assign w_hit_way  = w_match[1];
  // Prefer an empty way before consulting LRU.
  assign w_victim   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : w_lru);

  assign mem_read_data = w_hit ? w_way_data[w_hit_way][w_word] : '0;

  cache_set_array #(.SET_COUNT(SET_COUNT), .TAG_LEN(TAG_LEN)) u_array (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_index     (w_index),
    .o_valid     (w_valid),
    .o_tag       (w_way_tag),
    .o_data      (w_way_data),
    .o_lru       (w_lru),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_victim),
    .i_fill_tag  (w_tag),
    .i_fill_data ({sram_read_data, r_word0}),
    .i_upd_en    (w_upd_en),
    .i_upd_way   (w_hit_way),
    .i_upd_word  (w_word),
    .i_upd_data  (mem_write_data),
    .i_lru_en    (w_lru_en),
    .i_lru_val   (w_lru_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CACHE_IDLE;
      r_word0 <= '0;
    end else begin
      r_state <= w_next;
      if (w_word0_ld) r_word0 <= sram_read_data;
    end
  end

  always_comb begin
    w_next          = r_state;
    ready           = 1'b1;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_address    = '0;
    sram_write_data = '0;
    w_fill_en       = 1'b0;
    w_upd_en        = 1'b0;
    w_lru_en        = 1'b0;
    w_lru_val       = 1'b0;
    w_word0_ld      = 1'b0;
    case (r_state)
      CACHE_IDLE: begin
        if (mem_write_en) begin
          ready  = 1'b0;
          w_next = CACHE_WRITE;
        end else if (mem_read_en) begin
          if (w_hit) begin
            w_lru_en  = 1'b1;
            w_lru_val = ~w_hit_way;
          end else begin
            ready  = 1'b0;
            w_next = CACHE_FILL0;
          end
        end
      end
      CACHE_FILL0: begin
        ready        = 1'b0;
        sram_read_en = 1'b1;
        sram_address = {mem_address[ADDRESS_LEN-1:3], 3'b000};
        if (sram_ready) begin
          w_word0_ld = 1'b1;
          w_next     = CACHE_FILL1;
        end
      end
      CACHE_FILL1: begin
        ready        = 1'b0;
        sram_read_en = 1'b1;
        sram_address = {mem_address[ADDRESS_LEN-1:3], 3'b100};
        if (sram_ready) begin
          w_fill_en = 1'b1;
          w_lru_en  = 1'b1;
          w_lru_val = ~w_victim;
          w_next    = CACHE_IDLE;
        end
      end
      CACHE_WRITE: begin
        sram_write_en   = 1'b1;
        sram_address    = mem_address;
        sram_write_data = mem_write_data;
        ready           = sram_ready;
        if (sram_ready) begin
          // No-write-allocate: only a line already present is updated.
          w_upd_en  = w_hit;
          w_lru_en  = w_hit;
          w_lru_val = ~w_hit_way;
          w_next    = CACHE_IDLE;
        end
      end
      default: w_next = CACHE_IDLE;
    endcase
  end
endmodule
